// File: rtl/fix_field_arbiter.sv
// fix_field_arbiter
//
// Round-robin, message-atomic arbiter. Drains tag/value FIFO pairs from
// N_LANES FIX parser lanes onto one tag/value stream. A lane is granted on a
// header field (tag "8") and keeps the grant until its trailer field
// (tag "10") has been handed downstream, so fields of different messages
// never interleave. Messages reaching MAX_FIELDS without a trailer are
// force-closed. Fields that arrive outside a message are dropped.
//
// Ports
//   clk, rst          clock (rising edge), asynchronous active-low reset
//   t_empty_i/v_empty_i  per-lane tag/value FIFO empty flags
//   tag_i/value_i     per-lane FIFO read data (valid the cycle after a read)
//   t_rd_o/v_rd_o     per-lane FIFO read strobes (rd_cs and rd_en)
//   out_valid_o/out_ready_i  output handshake
//   out_tag_o, out_value_o, out_lane_o, out_som_o, out_eom_o  output field
//   err_orphan_o      pulse: orphan field dropped
//   err_trunc_o       pulse: message truncated at MAX_FIELDS
//   msg_count_o       completed messages (wraps)
//   drop_count_o      dropped orphan fields (saturates)
//   dbg_state_o       current FSM state
//
// Handshake: a field transfers on a cycle where out_valid_o and out_ready_i
// are both high. Once out_valid_o rises it stays high, with every out_*
// field unchanged, until that transfer happens. out_ready_i may be driven
// freely and is only looked at while out_valid_o is high.

module fix_field_arbiter #(
    parameter int N_LANES    = 2,
    parameter int MAX_FIELDS = 64
) (
    input  logic                   clk,
    input  logic                   rst,
    input  logic [N_LANES-1:0]     t_empty_i,
    input  logic [N_LANES-1:0]     v_empty_i,
    input  logic [32*N_LANES-1:0]  tag_i,
    input  logic [256*N_LANES-1:0] value_i,
    output logic [N_LANES-1:0]     t_rd_o,
    output logic [N_LANES-1:0]     v_rd_o,
    output logic                   out_valid_o,
    input  logic                   out_ready_i,
    output logic [31:0]            out_tag_o,
    output logic [255:0]           out_value_o,
    output logic [2:0]             out_lane_o,
    output logic                   out_som_o,
    output logic                   out_eom_o,
    output logic                   err_orphan_o,
    output logic                   err_trunc_o,
    output logic [15:0]            msg_count_o,
    output logic [7:0]             drop_count_o,
    output logic [2:0]             dbg_state_o
);

    localparam int              CW      = $clog2(MAX_FIELDS + 1);
    localparam logic [CW-1:0]   MAX_CNT = CW'(MAX_FIELDS);
    localparam logic [31:0]     TAG_SOM = 32'h0000_0038;
    localparam logic [31:0]     TAG_EOM = 32'h0000_3130;

    typedef enum logic [2:0] {
        IDLE = 3'd0,
        READ = 3'd1,
        CAPT = 3'd2,
        SEND = 3'd3,
        WAIT = 3'd4
    } state_t;

    state_t               state, state_nx;
    logic [2:0]           rr;
    logic [2:0]           grant;
    logic [2:0]           grant_nx;
    logic                 locked;
    logic [CW-1:0]        fcount;
    logic [CW-1:0]        fcount_nx;
    logic [N_LANES-1:0]   eligible;
    logic [N_LANES-1:0]   grant_onehot;
    logic                 grant_elig;
    logic                 any_elig;
    logic [2:0]           pick;
    logic [2:0]           hi_pick;
    logic [2:0]           lo_pick;
    logic                 hi_found;
    logic [31:0]          sel_tag;
    logic [255:0]         sel_value;
    logic                 is_som;
    logic                 is_eom;
    logic                 trunc_hit;

    // A lane is only eligible when both halves can be popped together.
    assign eligible    = ~t_empty_i & ~v_empty_i;
    assign grant_nx    = (grant == 3'(N_LANES - 1)) ? 3'd0 : grant + 3'd1;
    assign fcount_nx   = fcount + CW'(1);
    assign is_som      = (sel_tag == TAG_SOM);
    assign is_eom      = (sel_tag == TAG_EOM);
    // The field that brings the count to the limit closes the message.
    assign trunc_hit   = locked && (fcount_nx == MAX_CNT) && !is_eom;
    assign dbg_state_o = state;

    // Round-robin pick: lowest eligible lane at or above rr, otherwise the
    // lowest eligible lane overall (the wrap-around case).
    always_comb begin
        any_elig = |eligible;
        hi_found = 1'b0;
        hi_pick  = 3'd0;
        lo_pick  = 3'd0;
        for (int k = N_LANES - 1; k >= 0; k--) begin
            if (eligible[k]) begin
                lo_pick = 3'(k);
                if (3'(k) >= rr) begin
                    hi_found = 1'b1;
                    hi_pick  = 3'(k);
                end
            end
        end
        pick = hi_found ? hi_pick : lo_pick;
    end

    // Granted-lane selection of read data and eligibility.
    always_comb begin
        sel_tag      = '0;
        sel_value    = '0;
        grant_elig   = 1'b0;
        grant_onehot = '0;
        for (int k = 0; k < N_LANES; k++) begin
            if (grant == 3'(k)) begin
                sel_tag         = tag_i[32*k +: 32];
                sel_value       = value_i[256*k +: 256];
                grant_elig      = eligible[k];
                grant_onehot[k] = 1'b1;
            end
        end
    end

    always_ff @(posedge clk or negedge rst) begin
        if (!rst) begin
            state <= IDLE;
        end else begin
            state <= state_nx;
        end
    end

    always_comb begin
        state_nx     = state;
        t_rd_o       = '0;
        v_rd_o       = '0;
        out_valid_o  = 1'b0;
        err_orphan_o = 1'b0;
        err_trunc_o  = 1'b0;
        case (state)
            IDLE: begin
                if (any_elig) state_nx = READ;
            end
            READ: begin
                t_rd_o   = grant_onehot;
                v_rd_o   = grant_onehot;
                state_nx = CAPT;
            end
            CAPT: begin
                if (!locked && !is_som) begin
                    err_orphan_o = 1'b1;
                    state_nx     = IDLE;
                end else begin
                    err_trunc_o = trunc_hit;
                    state_nx    = SEND;
                end
            end
            SEND: begin
                out_valid_o = 1'b1;
                if (out_ready_i) begin
                    if (out_eom_o)       state_nx = IDLE;
                    else if (grant_elig) state_nx = READ;
                    else                 state_nx = WAIT;
                end
            end
            WAIT: begin
                if (grant_elig) state_nx = READ;
            end
            default: state_nx = IDLE;
        endcase
    end

    always_ff @(posedge clk or negedge rst) begin
        if (!rst) begin
            rr           <= 3'd0;
            grant        <= 3'd0;
            locked       <= 1'b0;
            fcount       <= '0;
            out_tag_o    <= '0;
            out_value_o  <= '0;
            out_lane_o   <= 3'd0;
            out_som_o    <= 1'b0;
            out_eom_o    <= 1'b0;
            msg_count_o  <= '0;
            drop_count_o <= '0;
        end else begin
            if (state == IDLE && any_elig) grant <= pick;

            if (state == CAPT) begin
                out_tag_o   <= sel_tag;
                out_value_o <= sel_value;
                out_lane_o  <= grant;
                if (!locked) begin
                    out_som_o <= is_som;
                    out_eom_o <= 1'b0;
                    if (is_som) begin
                        locked <= 1'b1;
                        fcount <= CW'(1);
                    end else begin
                        if (drop_count_o != 8'hFF) drop_count_o <= drop_count_o + 8'd1;
                        rr <= grant_nx;
                    end
                end else begin
                    // A header inside a message is just another field.
                    out_som_o <= 1'b0;
                    out_eom_o <= is_eom || trunc_hit;
                    fcount    <= fcount_nx;
                end
            end

            if (state == SEND && out_ready_i && out_eom_o) begin
                locked      <= 1'b0;
                rr          <= grant_nx;
                msg_count_o <= msg_count_o + 16'd1;
            end
        end
    end

endmodule

// File: doc/fix_field_arbiter.md
# fix_field_arbiter

Round-robin, message-atomic arbiter that drains tag/value FIFO pairs from N FIX parser lanes onto one tag/value stream. Sits between the per-lane tag/value FIFOs and the downstream field consumer. A lane is granted on a header field (tag "8") and holds the grant until its trailer field (tag "10") is forwarded, so fields of different messages never interleave.

## Interface
- N_LANES, 2: number of parser lanes, 2..8
- MAX_FIELDS, 64: field limit per message, including header and trailer
- clk  in  1  single clock, rising edge
- rst  in  1  reset, asynchronous, active-low
- t_empty_i  in  N_LANES  per-lane tag FIFO empty
- v_empty_i  in  N_LANES  per-lane value FIFO empty
- tag_i  in  32*N_LANES  per-lane tag FIFO read data; lane k is bits [32k+31:32k]
- value_i  in  256*N_LANES  per-lane value FIFO read data; lane k is bits [256k+255:256k]
- t_rd_o  out  N_LANES  per-lane tag FIFO read strobe; drives both rd_cs and rd_en
- v_rd_o  out  N_LANES  per-lane value FIFO read strobe; drives both rd_cs and rd_en
- out_valid_o  out  1  output field valid
- out_ready_i  in  1  downstream accept
- out_tag_o  out  32  forwarded tag
- out_value_o  out  256  forwarded value
- out_lane_o  out  3  source lane index
- out_som_o  out  1  field is a message header (tag 32'h0000_0038)
- out_eom_o  out  1  field ends the message (tag 32'h0000_3130, or truncation)
- err_orphan_o  out  1  one-cycle pulse: a field arrived outside a message and was dropped
- err_trunc_o  out  1  one-cycle pulse: message forced closed at MAX_FIELDS
- msg_count_o  out  16  completed messages; wraps
- drop_count_o  out  8  dropped orphan fields; saturates at 255

## Operation
- A lane is eligible when both `!t_empty_i[k]` and `!v_empty_i[k]` are true.
- FIFO read data is valid in the cycle after the read strobe (registered read).
- The FSM has five states: IDLE, READ, CAPT, SEND, WAIT.
- IDLE, not locked:
  - Pick the first eligible lane at or after the round-robin pointer `rr`, searching upward with wrap.
  - Move to READ with `grant` set to that lane.
  - If no lane is eligible, stay in IDLE.
- READ: pulse `t_rd_o[grant]` and `v_rd_o[grant]` together for exactly one cycle, then go to CAPT.
- CAPT: register the granted lane's tag and value into the output registers, set `out_lane_o` to `grant`, then decode the tag.
  - Not locked, tag == "8":
    - Set `locked` and `out_som_o`, and set the field count to 1.
    - Go to SEND.
  - Not locked, any other tag:
    - Drop the field and pulse `err_orphan_o`.
    - Increment `drop_count_o` (saturating).
    - Set `rr` to `grant+1` mod N_LANES, then go to IDLE.
  - Locked:
    - Increment the field count.
    - Tag "10": set `out_eom_o`.
    - Field count == MAX_FIELDS without tag "10": set `out_eom_o` and pulse `err_trunc_o`.
    - Tag "8" while locked is forwarded as an ordinary field (`out_som_o` = 0).
    - Go to SEND.
- SEND: hold `out_valid_o` = 1 with all output fields stable until `out_ready_i` = 1.
  - On the handshake, with `out_eom_o` = 1:
    - Clear `locked`.
    - Set `rr` to `grant+1` mod N_LANES.
    - Increment `msg_count_o`.
    - Go to IDLE.
  - On the handshake, with `out_eom_o` = 0:
    - Go to READ if the granted lane is eligible in that same cycle.
    - Otherwise go to WAIT.
- WAIT: stay locked and ignore all other lanes. Go to READ when the granted lane becomes eligible.
- At most one lane's read strobes are ever asserted, never both halves of different lanes.
- There is no partial read: the tag and value of one field are always popped in the same cycle.

## Timing
- Reset (`rst` = 0, asynchronous):
  - FSM goes to IDLE; `rr`, `grant`, `locked` and the field count go to 0.
  - All outputs, both counters and all out_* registers go to 0.
  - No read strobe is asserted in any cycle while `rst` is low.
- Reset mid-operation: any in-flight or held field is discarded. After release the block restarts from IDLE.
- Latency, eligible lane seen in IDLE to `out_valid_o`: 3 cycles (IDLE, READ, CAPT; valid in the 4th).
- Back-to-back fields of a locked lane with `out_ready_i` tied high: one field every 3 cycles (SEND, READ, CAPT).
- `out_valid_o`, once asserted, never deasserts before the handshake; out_* fields do not change while it is high.
- `err_orphan_o` pulses in the CAPT cycle. `err_trunc_o` pulses in the CAPT cycle together with the capture.
- `msg_count_o` updates in the cycle after the eom handshake.

## Test plan
- Single lane, fields 8/9/35/10 with `out_ready_i` high:
  - Expect 4 outputs, with som only on tag 8 and eom only on tag 10.
  - Expect `msg_count_o` = 1 and 3 cycles from `t_rd_o` to `t_rd_o`.
- Lanes 0 and 1 both holding a complete 3-field message at time 0:
  - All of lane 0's fields are forwarded before any of lane 1's.
  - The next round starts with lane 1.
  - `out_lane_o` never toggles mid-message.
- Lane 0 starts with tag 35 (no header):
  - That field is dropped, `err_orphan_o` pulses once and `drop_count_o` = 1.
  - Lane 1's valid message is then forwarded.
- MAX_FIELDS = 4 with a message of 8/9/35/49/10:
  - The 4th field (49) is emitted with eom and `err_trunc_o` pulses.
  - The trailing 10 is then dropped as an orphan.
- Backpressure: hold `out_ready_i` low for 10 cycles in SEND.
  - Outputs stay stable and no read strobe is asserted.
  - Release: the handshake completes in 1 cycle.
- Assert `rst` low during WAIT of a locked message:
  - All outputs go to 0 immediately.
  - After release, the next header from any lane is granted starting from lane 0.
